// File: rtl/abc_seq_pkg.sv
// abc_seq_pkg -- shared types and default widths for the abc_seq_gen block.
//   abc_state_e : sequencer FSM states
//   ABC_CNT_W   : default width of the burst count / seq_cnt
//   ABC_GAP_W   : default width of the inter-sequence gap
package abc_seq_pkg;

  localparam int ABC_CNT_W = 8;
  localparam int ABC_GAP_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    PH_A,
    PH_B,
    PH_C,
    GAP
  } abc_state_e;

endpackage

// File: rtl/abc_seq_gen_if.sv
// abc_seq_gen_if -- request/response and sequence-line bundle of abc_seq_gen.
//   start, count, gap, abort : burst request side (driven by master)
//   ready, a, b, c, done     : status and sequence lines (driven by slave)
//   seq_cnt                  : sequences completed in current/last burst
// Modports: master (requester / bench), slave (the generator).
interface abc_seq_gen_if
  import abc_seq_pkg::*;
#(
  parameter int CNT_W = ABC_CNT_W,
  parameter int GAP_W = ABC_GAP_W
);

  logic             start;
  logic [CNT_W-1:0] count;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             ready;
  logic             a;
  logic             b;
  logic             c;
  logic             done;
  logic [CNT_W-1:0] seq_cnt;

  modport master (
    output start, count, gap, abort,
    input  ready, a, b, c, done, seq_cnt
  );

  modport slave (
    input  start, count, gap, abort,
    output ready, a, b, c, done, seq_cnt
  );

endinterface

// File: rtl/abc_gap_timer.sv
// abc_gap_timer -- loadable down-counter timing the idle gap between sequences.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (issued on the PH_C -> GAP transition)
//   load_val   : gap length in cycles
//   en         : count down (high while the FSM sits in GAP)
//   expire     : high during the last GAP cycle
module abc_gap_timer #(
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [GAP_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - GAP_W'(1);
    end
  end

  // The counter holds the full gap in the first GAP cycle, so reaching 1
  // marks the final idle cycle.
  assign expire = (cnt == GAP_W'(1));

endmodule

// File: rtl/abc_seq_gen.sv
// abc_seq_gen -- emits bursts of a ##1 b ##1 c sequences separated by a
// programmable idle gap, feeding the abc protocol checker.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : abc_seq_gen_if.slave (start/count/gap/abort in;
//                ready/a/b/c/done/seq_cnt out)
// Optional: define ABC_SEQ_GEN_SVA_EN to compile embedded protocol assertions.
module abc_seq_gen
  import abc_seq_pkg::*;
#(
  parameter int CNT_W = ABC_CNT_W,
  parameter int GAP_W = ABC_GAP_W
) (
  input  logic         clk,
  input  logic         rst_n,
  abc_seq_gen_if.slave bus
);

  abc_state_e       state;
  abc_state_e       state_next;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] seq_cnt_q;
  logic [CNT_W-1:0] seq_cnt_inc;
  logic [GAP_W-1:0] gap_q;
  logic             accept;
  logic             inc;
  logic             load_timer;
  logic             done_next;
  logic             expire;
  logic             a_q;
  logic             b_q;
  logic             c_q;
  logic             done_q;

  assign seq_cnt_inc = seq_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    inc        = 1'b0;
    load_timer = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          accept = 1'b1;
          // A zero-length burst completes at once without touching the lines.
          if (bus.count == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = PH_A;
          end
        end
      end
      PH_A: state_next = PH_B;
      PH_B: state_next = PH_C;
      PH_C: begin
        inc = 1'b1;
        if (seq_cnt_inc == count_q) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else if (gap_q == '0) begin
          state_next = PH_A;
        end else begin
          state_next = GAP;
          load_timer = 1'b1;
        end
      end
      GAP: begin
        if (expire) begin
          state_next = PH_A;
        end
      end
      default: state_next = IDLE;
    endcase
    // Abort overrides everything: no done, seq_cnt frozen, lines drop.
    if (bus.abort) begin
      state_next = IDLE;
      accept     = 1'b0;
      inc        = 1'b0;
      load_timer = 1'b0;
      done_next  = 1'b0;
    end
  end

  // Lines are registered from the next state so they track the FSM phase
  // exactly while staying glitch-free at the checker input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      gap_q     <= '0;
      seq_cnt_q <= '0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      c_q       <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (accept) begin
        count_q   <= bus.count;
        gap_q     <= bus.gap;
        seq_cnt_q <= '0;
      end else if (inc) begin
        seq_cnt_q <= seq_cnt_inc;
      end
      a_q    <= (state_next == PH_A);
      b_q    <= (state_next == PH_B);
      c_q    <= (state_next == PH_C);
      done_q <= done_next;
    end
  end

  abc_gap_timer #(
    .GAP_W(GAP_W)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_timer),
    .load_val (gap_q),
    .en       (state == GAP),
    .expire   (expire)
  );

  assign bus.ready   = (state == IDLE);
  assign bus.a       = a_q;
  assign bus.b       = b_q;
  assign bus.c       = c_q;
  assign bus.done    = done_q;
  assign bus.seq_cnt = seq_cnt_q;

`ifdef ABC_SEQ_GEN_SVA_EN
  a_then_b: assert property (@(posedge clk) disable iff (!rst_n || bus.abort)
    bus.a |=> bus.b);
  b_then_c: assert property (@(posedge clk) disable iff (!rst_n || bus.abort)
    bus.b |=> bus.c);
  lines_onehot0: assert property (@(posedge clk) disable iff (!rst_n || bus.abort)
    $onehot0({bus.a, bus.b, bus.c}));
  // Zero-length bursts pulse done with no preceding c (seq_cnt stays 0).
  done_after_c: assert property (@(posedge clk) disable iff (!rst_n || bus.abort)
    (bus.done && (bus.seq_cnt != '0)) |-> $past(bus.c));
`endif

endmodule

// File: tb/tb_abc_seq_gen.sv
// tb_abc_seq_gen -- directed scoreboard bench for abc_seq_gen.
// Expected per-cycle outputs are queued when a request is driven and
// compared cycle by cycle as the generator produces them.
module tb_abc_seq_gen;

  typedef struct packed {
    logic       drv_abort;
    logic       a;
    logic       b;
    logic       c;
    logic       done;
    logic       ready;
    logic [7:0] seq_cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb[$];

  abc_seq_gen_if #(.CNT_W(8), .GAP_W(4)) bus ();

  abc_seq_gen #(
    .CNT_W(8),
    .GAP_W(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] obsVec();
    return {bus.a, bus.b, bus.c, bus.done, bus.ready, bus.seq_cnt};
  endfunction

  function automatic exp_t mk(input logic ab, input logic a, input logic b,
                              input logic c, input logic dn, input logic rdy,
                              input int sc);
    exp_t e;
    e.drv_abort = ab;
    e.a         = a;
    e.b         = b;
    e.c         = c;
    e.done      = dn;
    e.ready     = rdy;
    e.seq_cnt   = 8'(sc);
    return e;
  endfunction

  task automatic checkVec(input string tag, input logic [12:0] obs,
                          input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: got a,b,c,done,ready=%b seq_cnt=%0d, want a,b,c,done,ready=%b seq_cnt=%0d",
             tag, obs[12:8], obs[7:0], exp[12:8], exp[7:0]);
    end
  endtask

  // Reference trace of a burst: abort_seq/abort_phase mark where abort is
  // raised (abort_seq < 0 means run to completion).
  task automatic pushBurst(input int cnt, input int gp, input int abort_seq,
                           input int abort_phase);
    if (cnt == 0) begin
      sb.push_back(mk(0, 0, 0, 0, 1, 1, 0));
      sb.push_back(mk(0, 0, 0, 0, 0, 1, 0));
      return;
    end
    for (int s = 0; s < cnt; s++) begin
      for (int p = 0; p < 3; p++) begin
        logic ab;
        ab = (s == abort_seq) && (p == abort_phase);
        sb.push_back(mk(ab, p == 0, p == 1, p == 2, 0, 0, s));
        if (ab) begin
          sb.push_back(mk(0, 0, 0, 0, 0, 1, s));
          sb.push_back(mk(0, 0, 0, 0, 0, 1, s));
          sb.push_back(mk(0, 0, 0, 0, 0, 1, s));
          return;
        end
      end
      if (s < cnt - 1) begin
        for (int g = 0; g < gp; g++) begin
          sb.push_back(mk(0, 0, 0, 0, 0, 0, s + 1));
        end
      end
    end
    sb.push_back(mk(0, 0, 0, 0, 1, 1, cnt));
    sb.push_back(mk(0, 0, 0, 0, 0, 1, cnt));
  endtask

  task automatic applyStimulus(input int cnt, input int gp, input logic st,
                               input logic ab);
    @(posedge clk);
    #1;
    bus.start = st;
    bus.abort = ab;
    bus.count = 8'(cnt);
    bus.gap   = 4'(gp);
  endtask

  task automatic checkOutput(input string tag);
    int k;
    exp_t e;
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.abort = e.drv_abort;
      @(negedge clk);
      k++;
      checkVec($sformatf("%s cyc%0d", tag, k), obsVec(),
               {e.a, e.b, e.c, e.done, e.ready, e.seq_cnt});
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.count = '0;
    bus.gap   = '0;

    repeat (2) @(posedge clk);
    #1;
    checkVec("reset", obsVec(), {5'b00001, 8'd0});
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single sequence, gap 0");
    applyStimulus(1, 0, 1'b1, 1'b0);
    pushBurst(1, 0, -1, 0);
    checkOutput("cnt1_gap0");

    $display("[TB] three sequences, gap 2");
    applyStimulus(3, 2, 1'b1, 1'b0);
    pushBurst(3, 2, -1, 0);
    checkOutput("cnt3_gap2");

    $display("[TB] four back-to-back sequences");
    applyStimulus(4, 0, 1'b1, 1'b0);
    pushBurst(4, 0, -1, 0);
    checkOutput("cnt4_gap0");

    $display("[TB] abort in PH_B of second sequence");
    applyStimulus(5, 1, 1'b1, 1'b0);
    pushBurst(5, 1, 1, 1);
    checkOutput("abort_phb");

    $display("[TB] start with abort in IDLE");
    applyStimulus(2, 0, 1'b1, 1'b1);
    repeat (4) sb.push_back(mk(0, 0, 0, 0, 0, 1, 1));
    checkOutput("start_abort");

    $display("[TB] zero-length burst");
    applyStimulus(0, 3, 1'b1, 1'b0);
    pushBurst(0, 3, -1, 0);
    sb.push_back(mk(0, 0, 0, 0, 0, 1, 0));
    checkOutput("cnt0");

    $display("[TB] reset during GAP");
    applyStimulus(8, 3, 1'b1, 1'b0);
    sb.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 1, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 1));
    checkOutput("pre_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkVec("async_reset", obsVec(), {5'b00001, 8'd0});
    @(posedge clk);
    #1;
    checkVec("held_reset", obsVec(), {5'b00001, 8'd0});
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] burst after reset");
    applyStimulus(1, 0, 1'b1, 1'b0);
    pushBurst(1, 0, -1, 0);
    checkOutput("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
